select_bank: RTL

- Parametrised peripheral select generator for the cpu8080 system; next generation of the four-channel select unit.
- Provides NSEL programmable address-decode channels, a bootstrap (shadow-ROM) mode, and per-channel programmable wait-state generation that drives the CPU wait request.
- Lives in I/O space only.
- Sits between the cpu8080 bus and the ROM, RAM and peripherals.

---
 rtl/select_bank.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/select_bank.sv
// select_bank: I/O-mapped peripheral select generator with programmable
// address-decode channels, bootstrap select forcing and per-channel wait states.
module select_bank #(
    parameter int         NSEL     = 4,
    parameter logic [2:0] BASE     = 3'b000,
    parameter int         WSBITS   = 3,
    parameter int         BOOTWAIT = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     addr,
    inout  wire  [7:0]      data,
    input  logic            readmem,
    input  logic            writemem,
    input  logic            readio,
    input  logic            writeio,
    output logic [NSEL-1:0] select,
    output logic            bootstrap,
    output logic            waitr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic [2:0]        r_base;
    logic              r_wen;
    logic              r_boot;
    logic [5:0]        r_mask [NSEL];
    logic              r_io   [NSEL];
    logic              r_en   [NSEL];
    logic [5:0]        r_comp [NSEL];
    logic [WSBITS-1:0] r_wait [NSEL];
    logic              r_hit;
    logic [2:0]        r_idx;
    logic              r_strb_d;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WSBITS-1:0] r_cnt;
    logic [WSBITS-1:0] w_cnt_nxt;
    logic              r_waitr;
    logic              w_waitr_nxt;

    logic              w_acc;
    logic [4:0]        w_off;
    logic              w_strb;
    logic              w_start;
    logic              w_io_cyc;
    logic              w_mem_cyc;
    logic [NSEL-1:0]   w_match;
    logic [NSEL-1:0]   w_elig;
    logic              w_hit;
    logic [2:0]        w_hit_idx;
    logic [WSBITS-1:0] w_hit_wait;
    logic [WSBITS-1:0] w_n;
    logic [7:0]        w_rdata;
    logic              w_unused;

    assign w_acc     = (addr[7:5] == r_base);
    assign w_off     = addr[4:0];
    assign w_io_cyc  = readio | writeio;
    assign w_mem_cyc = readmem | writemem;
    assign w_strb    = w_io_cyc | w_mem_cyc;
    assign w_start   = w_strb & ~r_strb_d;
    assign w_unused  = &{1'b0, addr[9:8]};

    // I/O channels decode addr[7:2], memory channels decode addr[15:10].
    always_comb begin
        w_match = '0;
        w_elig  = '0;
        for (int i = 0; i < NSEL; i++) begin
            w_match[i] = r_en[i] &
                (((r_io[i] ? addr[7:2] : addr[15:10]) & r_mask[i]) == r_comp[i]);
            w_elig[i]  = w_match[i] & (r_io[i] ? w_io_cyc : w_mem_cyc);
        end
    end

    // Walk downwards so the lowest-numbered eligible channel wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_wait = '0;
        for (int i = NSEL - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_hit      = 1'b1;
                w_hit_idx  = 3'(i);
                w_hit_wait = r_wait[i];
            end
        end
    end

    always_comb begin
        w_n = '0;
        if (!r_wen) begin
            w_n = '0;
        end else if (w_hit) begin
            w_n = w_hit_wait;
        end else if (r_boot && w_mem_cyc) begin
            w_n = WSBITS'(BOOTWAIT);
        end
    end

    always_comb begin
        select = w_match;
        if (r_boot) begin
            select[1:0] = 2'b11;
        end
    end

    assign bootstrap = r_boot;
    assign waitr     = r_waitr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_base <= BASE;
            r_wen  <= 1'b1;
            r_boot <= 1'b1;
            for (int i = 0; i < NSEL; i++) begin
                r_mask[i] <= '0;
                r_io[i]   <= 1'b0;
                r_en[i]   <= 1'b0;
                r_comp[i] <= '0;
                r_wait[i] <= '0;
            end
        end else if (writeio && w_acc) begin
            if (w_off == 5'd0) begin
                r_base <= data[7:5];
                r_wen  <= data[1];
                r_boot <= data[0];
            end
            for (int i = 0; i < NSEL; i++) begin
                if (w_off[4:2] == 3'(i + 1)) begin
                    case (w_off[1:0])
                        2'd0: begin
                            r_mask[i] <= data[7:2];
                            r_io[i]   <= data[1];
                            r_en[i]   <= data[0];
                        end
                        2'd1:    r_comp[i] <= data[7:2];
                        2'd2:    r_wait[i] <= data[WSBITS-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_off == 5'd0) begin
            w_rdata = {r_base, 3'b000, r_wen, r_boot};
        end else if (w_off == 5'd1) begin
            w_rdata = {4'b0000, r_hit, r_idx};
        end
        for (int i = 0; i < NSEL; i++) begin
            if (w_off[4:2] == 3'(i + 1)) begin
                case (w_off[1:0])
                    2'd0:    w_rdata = {r_mask[i], r_io[i], r_en[i]};
                    2'd1:    w_rdata = {r_comp[i], 2'b00};
                    2'd2:    w_rdata = 8'(r_wait[i]);
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    assign data = (readio && w_acc) ? w_rdata : 8'bz;

    // STATUS keeps the last index on a miss; only hit is cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_strb_d <= 1'b0;
            r_hit    <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_strb_d <= w_strb;
            if (w_start) begin
                r_hit <= w_hit;
                if (w_hit) begin
                    r_idx <= w_hit_idx;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_waitr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_waitr <= w_waitr_nxt;
        end
    end

    // waitr rises on the start edge and falls on the edge that sees count 1,
    // giving exactly n high clocks unless the strobe drops first.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_waitr_nxt = r_waitr;
        case (r_state)
            IDLE: begin
                w_waitr_nxt = 1'b0;
                if (w_start) begin
                    if (w_n != '0) begin
                        w_state_nxt = COUNT;
                        w_cnt_nxt   = w_n;
                        w_waitr_nxt = 1'b1;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            COUNT: begin
                if (!w_strb) begin
                    w_state_nxt = IDLE;
                    w_waitr_nxt = 1'b0;
                end else if (r_cnt == WSBITS'(1)) begin
                    w_state_nxt = HOLD;
                    w_waitr_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - WSBITS'(1);
                end
            end
            HOLD: begin
                w_waitr_nxt = 1'b0;
                if (!w_strb) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_waitr_nxt = 1'b0;
            end
        endcase
    end

endmodule
